// File: rtl/mem_arb.sv
// Two-requester arbiter (instruction fetch IM, data DM) onto one shared memory port.
// One transaction outstanding at a time; round-robin or DM-first fixed priority.
//
//   state | meaning
//   IDLE  | no transaction; grant one valid requester, ready given combinationally
//   ISSUE | latched request presented on the bus until bus_req_ready
//   WAIT  | request accepted; forward bus response to the owner, then back to IDLE
module mem_arb #(
   parameter bit RR_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] im_req_addr,
   input  logic        im_req_valid,
   output logic        im_req_ready,
   output logic [63:0] im_resp_rdata,
   output logic        im_resp_valid,
   input  logic [63:0] dm_req_addr,
   input  logic [63:0] dm_req_wdata,
   input  logic [7:0]  dm_req_wmask,
   input  logic        dm_req_wen,
   input  logic        dm_req_valid,
   output logic        dm_req_ready,
   output logic [63:0] dm_resp_rdata,
   output logic        dm_resp_valid,
   output logic [63:0] bus_req_addr,
   output logic [63:0] bus_req_wdata,
   output logic [7:0]  bus_req_wmask,
   output logic        bus_req_wen,
   output logic        bus_req_valid,
   input  logic        bus_req_ready,
   input  logic [63:0] bus_resp_rdata,
   input  logic        bus_resp_valid,
   output logic        err_spurious
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [63:0] lat_addr;
   logic [63:0] lat_wdata;
   logic [7:0]  lat_wmask;
   logic        lat_wen;
   logic        owner_dm;
   logic        last_dm;
   logic        grant_im;
   logic        grant_dm;
   logic        spurious;

   // DM wins unless IM is also asking and, in round-robin mode, DM had the last grant.
   always_comb begin
      grant_dm = dm_req_valid && (!im_req_valid || !RR_EN || !last_dm);
      grant_im = im_req_valid && !grant_dm;
   end

   always_comb begin
      state_nxt     = state;
      im_req_ready  = 1'b0;
      dm_req_ready  = 1'b0;
      bus_req_valid = 1'b0;
      im_resp_valid = 1'b0;
      dm_resp_valid = 1'b0;
      im_resp_rdata = '0;
      dm_resp_rdata = '0;
      spurious      = 1'b0;
      case (state)
         IDLE: begin
            im_req_ready = grant_im;
            dm_req_ready = grant_dm;
            spurious     = bus_resp_valid;
            if (grant_im || grant_dm) state_nxt = ISSUE;
         end
         ISSUE: begin
            bus_req_valid = 1'b1;
            spurious      = bus_resp_valid;
            if (bus_req_ready) state_nxt = WAIT;
         end
         WAIT: begin
            if (bus_resp_valid) begin
               if (owner_dm) begin
                  dm_resp_valid = 1'b1;
                  dm_resp_rdata = bus_resp_rdata;
               end else begin
                  im_resp_valid = 1'b1;
                  im_resp_rdata = bus_resp_rdata;
               end
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Handshakes must stay quiet while reset is held, even though state is only cleared on the edge.
      if (rst) begin
         im_req_ready  = 1'b0;
         dm_req_ready  = 1'b0;
         bus_req_valid = 1'b0;
         im_resp_valid = 1'b0;
         dm_resp_valid = 1'b0;
         im_resp_rdata = '0;
         dm_resp_rdata = '0;
         spurious      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         last_dm      <= 1'b0;
         owner_dm     <= 1'b0;
         lat_addr     <= '0;
         lat_wdata    <= '0;
         lat_wmask    <= '0;
         lat_wen      <= 1'b0;
         err_spurious <= 1'b0;
      end else begin
         state <= state_nxt;
         if (dm_req_ready) begin
            lat_addr  <= dm_req_addr;
            lat_wdata <= dm_req_wdata;
            lat_wmask <= dm_req_wmask;
            lat_wen   <= dm_req_wen;
            owner_dm  <= 1'b1;
            last_dm   <= 1'b1;
         end else if (im_req_ready) begin
            lat_addr  <= im_req_addr;
            lat_wdata <= '0;
            lat_wmask <= '0;
            lat_wen   <= 1'b0;
            owner_dm  <= 1'b0;
            last_dm   <= 1'b0;
         end
         if (spurious) err_spurious <= 1'b1;
      end
   end

   assign bus_req_addr  = lat_addr;
   assign bus_req_wdata = lat_wdata;
   assign bus_req_wmask = lat_wmask;
   assign bus_req_wen   = lat_wen;

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: a transaction-level model predicts grant order, bus requests
// and owner responses; independent monitors compare what the DUT presents.
module tb_mem_arb;

   typedef struct packed {
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [7:0]  wmask;
      logic        wen;
   } bus_t;

   typedef struct packed {
      logic        dm;
      logic [63:0] rdata;
   } resp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic [63:0] im_req_addr = '0;
   logic        im_req_valid = 1'b0;
   logic        im_req_ready;
   logic [63:0] im_resp_rdata;
   logic        im_resp_valid;
   logic [63:0] dm_req_addr = '0;
   logic [63:0] dm_req_wdata = '0;
   logic [7:0]  dm_req_wmask = '0;
   logic        dm_req_wen = 1'b0;
   logic        dm_req_valid = 1'b0;
   logic        dm_req_ready;
   logic [63:0] dm_resp_rdata;
   logic        dm_resp_valid;
   logic [63:0] bus_req_addr;
   logic [63:0] bus_req_wdata;
   logic [7:0]  bus_req_wmask;
   logic        bus_req_wen;
   logic        bus_req_valid;
   logic        bus_req_ready;
   logic [63:0] bus_resp_rdata;
   logic        bus_resp_valid;
   logic        err_spurious;

   // auto responder (a_*) and manual stimulus (m_*) are merged onto the bus inputs
   logic        a_ready = 1'b0, m_ready = 1'b0;
   logic        a_rv = 1'b0, m_rv = 1'b0;
   logic [63:0] a_rd = '0, m_rd = '0;
   assign bus_req_ready  = a_ready | m_ready;
   assign bus_resp_valid = a_rv | m_rv;
   assign bus_resp_rdata = a_rd | m_rd;

   mem_arb #(.RR_EN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .im_req_addr(im_req_addr), .im_req_valid(im_req_valid), .im_req_ready(im_req_ready),
      .im_resp_rdata(im_resp_rdata), .im_resp_valid(im_resp_valid),
      .dm_req_addr(dm_req_addr), .dm_req_wdata(dm_req_wdata), .dm_req_wmask(dm_req_wmask),
      .dm_req_wen(dm_req_wen), .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready),
      .dm_resp_rdata(dm_resp_rdata), .dm_resp_valid(dm_resp_valid),
      .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_wmask(bus_req_wmask),
      .bus_req_wen(bus_req_wen), .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
      .bus_resp_rdata(bus_resp_rdata), .bus_resp_valid(bus_resp_valid),
      .err_spurious(err_spurious)
   );

   // fixed-priority instance
   logic        f_rst = 1'b1;
   logic [63:0] f_im_req_addr = '0;
   logic        f_im_req_valid = 1'b0;
   logic        f_im_req_ready;
   logic [63:0] f_im_resp_rdata;
   logic        f_im_resp_valid;
   logic [63:0] f_dm_req_addr = '0;
   logic        f_dm_req_valid = 1'b0;
   logic        f_dm_req_ready;
   logic [63:0] f_dm_resp_rdata;
   logic        f_dm_resp_valid;
   logic [63:0] f_bus_req_addr;
   logic [63:0] f_bus_req_wdata;
   logic [7:0]  f_bus_req_wmask;
   logic        f_bus_req_wen;
   logic        f_bus_req_valid;
   logic        f_bus_req_ready = 1'b0;
   logic [63:0] f_bus_resp_rdata = '0;
   logic        f_bus_resp_valid = 1'b0;
   logic        f_err_spurious;

   mem_arb #(.RR_EN(1'b0)) dut_fp (
      .clk(clk), .rst(f_rst),
      .im_req_addr(f_im_req_addr), .im_req_valid(f_im_req_valid), .im_req_ready(f_im_req_ready),
      .im_resp_rdata(f_im_resp_rdata), .im_resp_valid(f_im_resp_valid),
      .dm_req_addr(f_dm_req_addr), .dm_req_wdata(64'h0), .dm_req_wmask(8'h0),
      .dm_req_wen(1'b0), .dm_req_valid(f_dm_req_valid), .dm_req_ready(f_dm_req_ready),
      .dm_resp_rdata(f_dm_resp_rdata), .dm_resp_valid(f_dm_resp_valid),
      .bus_req_addr(f_bus_req_addr), .bus_req_wdata(f_bus_req_wdata), .bus_req_wmask(f_bus_req_wmask),
      .bus_req_wen(f_bus_req_wen), .bus_req_valid(f_bus_req_valid), .bus_req_ready(f_bus_req_ready),
      .bus_resp_rdata(f_bus_resp_rdata), .bus_resp_valid(f_bus_resp_valid),
      .err_spurious(f_err_spurious)
   );

   int chk_cnt = 0;
   int pass_cnt = 0;

   bit    grant_q[$];
   bus_t  bus_q[$];
   resp_t resp_q[$];
   bit    m_last_dm = 1'b0;
   bit    auto_bus = 1'b1;
   int    fix_rdy = -1;
   int    fix_rsp = -1;
   int    f_dm_resp_cnt = 0;
   int    f_im_resp_cnt = 0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: actual %0h required %0h", name, act, exp);
   endfunction

   function automatic void fail(string name, string act, string req);
      chk_cnt++;
      $display("FAIL %s: actual %s required %s", name, act, req);
   endfunction

   // memory contents seen through the shared port
   function automatic logic [63:0] resp_fn(logic [63:0] a);
      if (a == 64'h1000) return 64'hDEADBEEF;
      return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0F0F_1234_5678_9ABC;
   endfunction

   function automatic void push_txn(bit is_dm, logic [63:0] a, logic [63:0] wd,
                                    logic [7:0] wm, bit we, bit exp_resp);
      bus_t  b;
      resp_t r;
      grant_q.push_back(is_dm);
      b.addr  = a;
      b.wdata = is_dm ? wd : 64'h0;
      b.wmask = is_dm ? wm : 8'h0;
      b.wen   = is_dm ? we : 1'b0;
      bus_q.push_back(b);
      if (exp_resp) begin
         r.dm    = is_dm;
         r.rdata = resp_fn(a);
         resp_q.push_back(r);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one or both requests together and hold each until accepted.
   task automatic run_round(bit do_im, bit do_dm, logic [63:0] ia, logic [63:0] da,
                            logic [63:0] dwd, logic [7:0] dwm, bit dwen, bit exp_resp);
      bit pend_im, pend_dm, acc_im, acc_dm, win_dm;
      if (do_im && do_dm) begin
         win_dm = !m_last_dm;
         push_txn(win_dm, win_dm ? da : ia, dwd, dwm, dwen, exp_resp);
         push_txn(!win_dm, win_dm ? ia : da, dwd, dwm, dwen, exp_resp);
         m_last_dm = !win_dm;
      end else if (do_im) begin
         push_txn(1'b0, ia, dwd, dwm, dwen, exp_resp);
         m_last_dm = 1'b0;
      end else if (do_dm) begin
         push_txn(1'b1, da, dwd, dwm, dwen, exp_resp);
         m_last_dm = 1'b1;
      end
      tick();
      im_req_addr  = ia;
      im_req_valid = do_im;
      dm_req_addr  = da;
      dm_req_wdata = dwd;
      dm_req_wmask = dwm;
      dm_req_wen   = dwen;
      dm_req_valid = do_dm;
      pend_im = do_im;
      pend_dm = do_dm;
      for (int c = 0; c < 100 && (pend_im || pend_dm); c++) begin
         @(negedge clk);
         acc_im = im_req_ready;
         acc_dm = dm_req_ready;
         tick();
         if (acc_im) begin im_req_valid = 1'b0; pend_im = 1'b0; end
         if (acc_dm) begin dm_req_valid = 1'b0; pend_dm = 1'b0; end
      end
      if (pend_im || pend_dm) begin
         fail("accept_timeout", "pending", "accepted");
         im_req_valid = 1'b0;
         dm_req_valid = 1'b0;
      end
   endtask

   task automatic drain();
      for (int c = 0; c < 300 && (grant_q.size() != 0 || bus_q.size() != 0 || resp_q.size() != 0); c++)
         tick();
      if (grant_q.size() != 0 || bus_q.size() != 0 || resp_q.size() != 0) begin
         fail("drain_timeout", "outstanding", "empty");
         grant_q.delete();
         bus_q.delete();
         resp_q.delete();
      end
   endtask

   always @(negedge clk) begin : mon_grant
      if (im_req_ready && !im_req_valid) fail("im_ready_no_valid", "1", "0");
      if (dm_req_ready && !dm_req_valid) fail("dm_ready_no_valid", "1", "0");
      if (im_req_ready && dm_req_ready) fail("double_ready", "both", "one");
      else if (im_req_ready || dm_req_ready) begin
         if (grant_q.size() == 0) fail("unexpected_grant", "ready", "none");
         else check("grant_owner_dm", 64'(dm_req_ready), 64'(grant_q.pop_front()));
      end
   end

   always @(negedge clk) begin : mon_bus
      bus_t b;
      if (bus_req_valid) begin
         if (bus_q.size() == 0) fail("unexpected_bus_req", "valid", "none");
         else begin
            b = bus_q[0];
            check("bus_addr", bus_req_addr, b.addr);
            check("bus_wdata", bus_req_wdata, b.wdata);
            check("bus_wmask", 64'(bus_req_wmask), 64'(b.wmask));
            check("bus_wen", 64'(bus_req_wen), 64'(b.wen));
            if (bus_req_ready) bus_q.delete(0);
         end
      end
   end

   always @(negedge clk) begin : mon_resp
      resp_t r;
      if (im_resp_valid && dm_resp_valid) fail("double_resp", "both", "one");
      else if (im_resp_valid || dm_resp_valid) begin
         if (resp_q.size() == 0) fail("unexpected_resp", "valid", "none");
         else begin
            r = resp_q.pop_front();
            check("resp_owner_dm", 64'(dm_resp_valid), 64'(r.dm));
            check("resp_rdata", dm_resp_valid ? dm_resp_rdata : im_resp_rdata, r.rdata);
            check("resp_nonowner_rdata", dm_resp_valid ? im_resp_rdata : dm_resp_rdata, 64'h0);
         end
      end
   end

   always @(negedge clk) begin : mon_fp
      if (f_dm_resp_valid) f_dm_resp_cnt++;
      if (f_im_resp_valid) f_im_resp_cnt++;
   end

   initial begin : responder
      int d;
      logic [63:0] a;
      forever begin
         tick();
         if (auto_bus && bus_req_valid) begin
            d = (fix_rdy >= 0) ? fix_rdy : int'($urandom_range(0, 3));
            repeat (d) tick();
            a_ready = 1'b1;
            a = bus_req_addr;
            tick();
            a_ready = 1'b0;
            d = (fix_rsp >= 0) ? fix_rsp : int'($urandom_range(0, 3));
            repeat (d) tick();
            a_rv = 1'b1;
            a_rd = resp_fn(a);
            tick();
            a_rv = 1'b0;
            a_rd = '0;
         end
      end
   end

   initial begin : fp_responder
      forever begin
         tick();
         if (f_bus_req_valid) begin
            f_bus_req_ready = 1'b1;
            tick();
            f_bus_req_ready = 1'b0;
            f_bus_resp_valid = 1'b1;
            f_bus_resp_rdata = resp_fn(f_bus_req_addr);
            tick();
            f_bus_resp_valid = 1'b0;
            f_bus_resp_rdata = '0;
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: actual still running required finished");
      $fatal(1);
   end

   initial begin : main
      int   sel, n_dm;
      bit   im_seen;
      repeat (2) tick();
      // outputs stay quiet while reset is held, even with both requesters valid
      im_req_valid = 1'b1;
      dm_req_valid = 1'b1;
      @(negedge clk);
      check("rst_im_ready", 64'(im_req_ready), 64'h0);
      check("rst_dm_ready", 64'(dm_req_ready), 64'h0);
      check("rst_bus_valid", 64'(bus_req_valid), 64'h0);
      check("rst_err", 64'(err_spurious), 64'h0);
      check("rst_bus_addr", bus_req_addr, 64'h0);
      tick();
      im_req_valid = 1'b0;
      dm_req_valid = 1'b0;
      rst = 1'b0;
      m_last_dm = 1'b0;

      // contention right after reset: DM, IM, DM, IM
      run_round(1'b1, 1'b1, 64'h100, 64'h200, 64'h11, 8'hFF, 1'b0, 1'b1);
      run_round(1'b1, 1'b1, 64'h108, 64'h208, 64'h22, 8'hFF, 1'b1, 1'b1);
      drain();

      // IM read with a stalled bus
      fix_rdy = 3;
      fix_rsp = 0;
      run_round(1'b1, 1'b0, 64'h1000, 64'h0, 64'h0, 8'h0, 1'b0, 1'b1);
      drain();
      fix_rdy = -1;
      fix_rsp = -1;

      // DM write
      run_round(1'b0, 1'b1, 64'h0, 64'h20, 64'h55, 8'h0F, 1'b1, 1'b1);
      drain();

      for (int i = 0; i < 60; i++) begin
         sel = int'($urandom_range(1, 3));
         run_round(sel[0], sel[1], {$urandom, $urandom & 32'hFFFF_FFF8},
                   {$urandom, $urandom & 32'hFFFF_FFF8}, {$urandom, $urandom},
                   8'($urandom), 1'($urandom), 1'b1);
      end
      drain();

      // stray response in IDLE
      auto_bus = 1'b0;
      tick();
      m_rv = 1'b1;
      m_rd = 64'hBAD0;
      tick();
      m_rv = 1'b0;
      m_rd = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("err_sticky", 64'(err_spurious), 64'h1);
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_last_dm = 1'b0;
      @(negedge clk);
      check("err_cleared", 64'(err_spurious), 64'h0);

      // reset while waiting on the bus response
      run_round(1'b1, 1'b0, 64'h3000, 64'h0, 64'h0, 8'h0, 1'b0, 1'b0);
      @(negedge clk);
      check("issue_bus_valid", 64'(bus_req_valid), 64'h1);
      tick();
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      m_rv = 1'b1;
      m_rd = 64'h77;
      rst = 1'b1;
      @(negedge clk);
      check("rst_wait_im_resp", 64'(im_resp_valid), 64'h0);
      check("rst_wait_bus_valid", 64'(bus_req_valid), 64'h0);
      tick();
      rst = 1'b0;
      m_rv = 1'b0;
      m_rd = '0;
      m_last_dm = 1'b0;
      @(negedge clk);
      check("post_rst_bus_valid", 64'(bus_req_valid), 64'h0);
      check("post_rst_bus_addr", bus_req_addr, 64'h0);
      check("post_rst_im_resp", 64'(im_resp_valid), 64'h0);
      check("post_rst_err", 64'(err_spurious), 64'h0);
      tick();
      m_rv = 1'b1;
      m_rd = 64'h99;
      tick();
      m_rv = 1'b0;
      m_rd = '0;
      @(negedge clk);
      check("late_resp_err", 64'(err_spurious), 64'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_last_dm = 1'b0;
      auto_bus = 1'b1;
      run_round(1'b1, 1'b0, 64'h4000, 64'h0, 64'h0, 8'h0, 1'b0, 1'b1);
      drain();

      // fixed priority: DM takes every grant while both are held valid
      tick();
      f_rst = 1'b0;
      f_im_req_addr  = 64'h5000;
      f_im_req_valid = 1'b1;
      f_dm_req_addr  = 64'h6000;
      f_dm_req_valid = 1'b1;
      n_dm = 0;
      im_seen = 1'b0;
      for (int c = 0; c < 200 && n_dm < 3; c++) begin
         @(negedge clk);
         if (f_dm_req_ready) n_dm++;
         if (f_im_req_ready) im_seen = 1'b1;
         tick();
      end
      f_dm_req_valid = 1'b0;
      f_im_req_valid = 1'b0;
      for (int c = 0; c < 50 && f_dm_resp_cnt < 3; c++) tick();
      check("fp_dm_grants", 64'(n_dm), 64'd3);
      check("fp_im_ready_seen", 64'(im_seen), 64'h0);
      check("fp_dm_resps", 64'(f_dm_resp_cnt), 64'd3);
      check("fp_im_resps", 64'(f_im_resp_cnt), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
